// File: rtl/regfile_gazump_bypass_pkg.sv
// Shared sizing constants for the gazump bypass slice; the match vector layout mirrors
// regfile_get_gazump (bits 0..GZ_NWRITE-1 are write ports, bit GZ_RF_IDX is the regfile hit).
package regfile_gazump_bypass_pkg;

    localparam int unsigned GZ_NWRITE  = 10;
    localparam int unsigned GZ_MATCH_W = 11;
    localparam int unsigned GZ_RF_IDX  = 10;
    localparam int unsigned GZ_NREAD   = 9;
    localparam int unsigned GZ_DATA_W  = 65;

    localparam int unsigned GZ_CNT_W   = 16;
    localparam logic [GZ_CNT_W-1:0] GZ_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/regfile_gazump_bypass_sel.sv
// Per-read-port operand resolve: the lowest matching write port wins, otherwise regfile data.
// err flags a vector with several write hits or with no bit set at all.
module regfile_gazump_bypass_sel
    import regfile_gazump_bypass_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = GZ_DATA_W,
    parameter int unsigned NWRITE     = GZ_NWRITE
) (
    input  logic [NWRITE:0]             match,
    input  logic [DATA_WIDTH-1:0]        rf_data,
    input  logic [NWRITE*DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0]        operand,
    output logic                         fwd,
    output logic                         err
);

    logic seen;
    logic multi;

    always_comb begin
        operand = rf_data;
        fwd     = 1'b0;
        // Walk downwards so the lowest set bit is the last (and winning) assignment.
        for (int k = int'(NWRITE) - 1; k >= 0; k--) begin
            if (match[k]) begin
                operand = wr_data[k*DATA_WIDTH +: DATA_WIDTH];
                fwd     = 1'b1;
            end
        end
    end

    always_comb begin
        seen  = 1'b0;
        multi = 1'b0;
        for (int k = 0; k < int'(NWRITE); k++) begin
            if (match[k]) begin
                if (seen) begin
                    multi = 1'b1;
                end
                seen = 1'b1;
            end
        end
    end

    assign err = multi | ~(seen | match[NWRITE]);

endmodule

// File: rtl/regfile_gazump_bypass.sv
// Resolves every read port's operand from its gazump match vector and registers the result into a
// valid/ready stage with a one-entry skid buffer; also counts forwarded beats and flags bad vectors.
module regfile_gazump_bypass
    import regfile_gazump_bypass_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = GZ_DATA_W,
    parameter int unsigned NREAD      = GZ_NREAD,
    parameter int unsigned NWRITE     = GZ_NWRITE
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_vld,
    output logic                            in_rdy,
    input  logic [NREAD*(NWRITE+1)-1:0]     read_match,
    input  logic [NREAD*DATA_WIDTH-1:0]     rf_data,
    input  logic [NWRITE*DATA_WIDTH-1:0]    wr_data,
    output logic                            out_vld,
    input  logic                            out_rdy,
    output logic [NREAD*DATA_WIDTH-1:0]     out_data,
    output logic [NREAD-1:0]                out_fwd,
    input  logic                            cnt_clr,
    output logic [GZ_CNT_W-1:0]             fwd_cnt,
    output logic                            err_multi
);

    logic [NREAD*DATA_WIDTH-1:0] res_data;
    logic [NREAD-1:0]            res_fwd;
    logic [NREAD-1:0]            res_err;

    for (genvar r = 0; r < NREAD; r++) begin : g_port
        regfile_gazump_bypass_sel #(
            .DATA_WIDTH (DATA_WIDTH),
            .NWRITE     (NWRITE)
        ) u_sel (
            .match   (read_match[r*(NWRITE+1) +: NWRITE+1]),
            .rf_data (rf_data[r*DATA_WIDTH +: DATA_WIDTH]),
            .wr_data (wr_data),
            .operand (res_data[r*DATA_WIDTH +: DATA_WIDTH]),
            .fwd     (res_fwd[r]),
            .err     (res_err[r])
        );
    end

    logic                        out_vld_q, out_vld_d;
    logic [NREAD*DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [NREAD-1:0]            out_fwd_q, out_fwd_d;
    logic                        skid_vld_q, skid_vld_d;
    logic [NREAD*DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic [NREAD-1:0]            skid_fwd_q, skid_fwd_d;
    logic [GZ_CNT_W-1:0]         fwd_cnt_q, fwd_cnt_d;
    logic                        err_multi_q, err_multi_d;

    logic accept;
    logic out_load;

    assign in_rdy   = ~skid_vld_q;
    assign accept   = in_vld & in_rdy;
    assign out_load = ~out_vld_q | out_rdy;

    always_comb begin
        out_vld_d   = out_vld_q;
        out_data_d  = out_data_q;
        out_fwd_d   = out_fwd_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        skid_fwd_d  = skid_fwd_q;
        if (out_load) begin
            // A full skid blocks input (in_rdy=0), so it always drains ahead of new beats.
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_data_d = skid_data_q;
                out_fwd_d  = skid_fwd_q;
                skid_vld_d = 1'b0;
            end else begin
                out_vld_d = accept;
                if (accept) begin
                    out_data_d = res_data;
                    out_fwd_d  = res_fwd;
                end
            end
        end else if (accept) begin
            skid_vld_d  = 1'b1;
            skid_data_d = res_data;
            skid_fwd_d  = res_fwd;
        end
    end

    always_comb begin
        fwd_cnt_d = fwd_cnt_q;
        if (cnt_clr) begin
            fwd_cnt_d = '0;
        end else if (accept && (|res_fwd) && (fwd_cnt_q != GZ_CNT_MAX)) begin
            fwd_cnt_d = fwd_cnt_q + 1'b1;
        end
        err_multi_d = err_multi_q | (accept & (|res_err));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_vld_q   <= 1'b0;
            out_data_q  <= '0;
            out_fwd_q   <= '0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
            skid_fwd_q  <= '0;
            fwd_cnt_q   <= '0;
            err_multi_q <= 1'b0;
        end else begin
            out_vld_q   <= out_vld_d;
            out_data_q  <= out_data_d;
            out_fwd_q   <= out_fwd_d;
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
            skid_fwd_q  <= skid_fwd_d;
            fwd_cnt_q   <= fwd_cnt_d;
            err_multi_q <= err_multi_d;
        end
    end

    assign out_vld   = out_vld_q;
    assign out_data  = out_data_q;
    assign out_fwd   = out_fwd_q;
    assign fwd_cnt   = fwd_cnt_q;
    assign err_multi = err_multi_q;

endmodule

// File: tb/tb_regfile_gazump_bypass.sv
// Scoreboard bench for regfile_gazump_bypass: accepted beats are modelled and queued, then
// compared in order as the output handshakes; counter and error flag are tracked every cycle.
module tb_regfile_gazump_bypass;

    localparam int DW = 65;
    localparam int NR = 9;
    localparam int NW = 10;
    localparam int MW = 11;

    typedef logic [NR*DW-1:0] wide_t;
    typedef struct packed {
        logic [NR*DW-1:0] data;
        logic [NR-1:0]    fwd;
    } beat_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_vld;
    logic               in_rdy;
    logic [NR*MW-1:0]   read_match;
    logic [NR*DW-1:0]   rf_data;
    logic [NW*DW-1:0]   wr_data;
    logic               out_vld;
    logic               out_rdy;
    logic [NR*DW-1:0]   out_data;
    logic [NR-1:0]      out_fwd;
    logic               cnt_clr;
    logic [15:0]        fwd_cnt;
    logic               err_multi;

    always #5 clk = ~clk;

    regfile_gazump_bypass u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .read_match (read_match),
        .rf_data    (rf_data),
        .wr_data    (wr_data),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .out_data   (out_data),
        .out_fwd    (out_fwd),
        .cnt_clr    (cnt_clr),
        .fwd_cnt    (fwd_cnt),
        .err_multi  (err_multi)
    );

    int    checks = 0;
    int    errors = 0;
    beat_t sb[$];
    logic [15:0] m_cnt = '0;
    logic        m_err = 1'b0;

    task automatic check_eq(input string tag, input wide_t obs, input wide_t exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [NR*MW-1:0] m, input logic [NR*DW-1:0] rf,
                         input logic [NW*DW-1:0] wr, output beat_t b, output logic err);
        b   = '0;
        err = 1'b0;
        for (int r = 0; r < NR; r++) begin
            logic [MW-1:0] v;
            int hit;
            int n;
            v   = m[r*MW +: MW];
            hit = -1;
            n   = 0;
            for (int k = 0; k < NW; k++) begin
                if (v[k]) begin
                    n++;
                    if (hit < 0) hit = k;
                end
            end
            if (hit >= 0) begin
                b.data[r*DW +: DW] = wr[hit*DW +: DW];
                b.fwd[r]           = 1'b1;
            end else begin
                b.data[r*DW +: DW] = rf[r*DW +: DW];
            end
            if (n > 1 || v == '0) err = 1'b1;
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    task automatic rand_data();
        for (int r = 0; r < NR; r++) rf_data[r*DW +: DW] = rnd();
        for (int k = 0; k < NW; k++) wr_data[k*DW +: DW] = rnd();
    endtask

    task automatic set_all(input logic [MW-1:0] v);
        for (int r = 0; r < NR; r++) read_match[r*MW +: MW] = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: checks run on the falling edge, away from the active edge.
    beat_t mon_b;
    beat_t mon_got;
    logic  mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            sb.delete();
            m_cnt = '0;
            m_err = 1'b0;
        end else begin
            check_eq("fwd_cnt", wide_t'(fwd_cnt), wide_t'(m_cnt));
            check_eq("err_multi", wide_t'(err_multi), wide_t'(m_err));
            if (out_vld && out_rdy) begin
                if (sb.size() == 0) begin
                    check_eq("sb_unexpected_beat", wide_t'(1), wide_t'(0));
                end else begin
                    mon_got = sb.pop_front();
                    check_eq("sb_data", out_data, mon_got.data);
                    check_eq("sb_fwd", wide_t'(out_fwd), wide_t'(mon_got.fwd));
                end
            end
            if (in_vld && in_rdy) begin
                model(read_match, rf_data, wr_data, mon_b, mon_e);
                sb.push_back(mon_b);
                if (!cnt_clr && (mon_b.fwd != '0) && m_cnt != 16'hFFFF) m_cnt = m_cnt + 1'b1;
                if (mon_e) m_err = 1'b1;
            end
            if (cnt_clr) m_cnt = '0;
        end
    end

    beat_t ba, bb;
    logic  e;

    initial begin
        rst        = 1'b0;
        in_vld     = 1'b0;
        out_rdy    = 1'b0;
        cnt_clr    = 1'b0;
        read_match = '0;
        rf_data    = '0;
        wr_data    = '0;
        repeat (3) tick();
        check_eq("rst_out_vld", wide_t'(out_vld), wide_t'(0));
        check_eq("rst_in_rdy", wide_t'(in_rdy), wide_t'(1));
        check_eq("rst_out_data", out_data, wide_t'(0));
        check_eq("rst_out_fwd", wide_t'(out_fwd), wide_t'(0));
        check_eq("rst_fwd_cnt", wide_t'(fwd_cnt), wide_t'(0));
        check_eq("rst_err", wide_t'(err_multi), wide_t'(0));
        rst = 1'b1;
        tick();

        // Port0 forwards write port 2.
        out_rdy = 1'b1;
        rand_data();
        set_all(11'h400);
        read_match[0 +: MW] = 11'h004;
        in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
        check_eq("t1_vld", wide_t'(out_vld), wide_t'(1));
        check_eq("t1_data0", wide_t'(out_data[0 +: DW]), wide_t'(wr_data[2*DW +: DW]));
        check_eq("t1_fwd", wide_t'(out_fwd), wide_t'(9'h001));
        check_eq("t1_cnt", wide_t'(fwd_cnt), wide_t'(1));

        // Every port takes regfile data.
        rand_data();
        set_all(11'h400);
        in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
        check_eq("t2_data", out_data, rf_data);
        check_eq("t2_fwd", wide_t'(out_fwd), wide_t'(0));
        check_eq("t2_cnt", wide_t'(fwd_cnt), wide_t'(1));
        tick();

        // Stall: A in output, B into skid, C ignored.
        out_rdy = 1'b0;
        rand_data();
        set_all(11'h200);
        model(read_match, rf_data, wr_data, ba, e);
        in_vld = 1'b1;
        tick();
        rand_data();
        set_all(11'h010);
        model(read_match, rf_data, wr_data, bb, e);
        tick();
        check_eq("t3_in_rdy_low", wide_t'(in_rdy), wide_t'(0));
        check_eq("t3_hold_a", out_data, ba.data);
        rand_data();
        set_all(11'h001);
        tick();
        check_eq("t3_still_a", out_data, ba.data);
        check_eq("t3_still_blocked", wide_t'(in_rdy), wide_t'(0));
        out_rdy = 1'b1;
        tick();
        in_vld = 1'b0;
        check_eq("t3_out_b", out_data, bb.data);
        check_eq("t3_out_vld_b", wide_t'(out_vld), wide_t'(1));
        check_eq("t3_in_rdy_back", wide_t'(in_rdy), wide_t'(1));
        tick();
        check_eq("t3_drained", wide_t'(out_vld), wide_t'(0));

        // Multi-hit and empty vectors.
        rand_data();
        set_all(11'h400);
        read_match[3*MW +: MW] = 11'h00A;
        in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
        check_eq("t4_multi_data", wide_t'(out_data[3*DW +: DW]), wide_t'(wr_data[1*DW +: DW]));
        check_eq("t4_multi_err", wide_t'(err_multi), wide_t'(1));
        rand_data();
        read_match[3*MW +: MW] = 11'h400;
        read_match[0 +: MW]    = 11'h000;
        in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
        check_eq("t4_zero_data", wide_t'(out_data[0 +: DW]), wide_t'(rf_data[0 +: DW]));
        check_eq("t4_zero_err", wide_t'(err_multi), wide_t'(1));
        set_all(11'h400);
        in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
        check_eq("t4_sticky", wide_t'(err_multi), wide_t'(1));

        // Saturate the counter, then clear together with a forwarded beat.
        set_all(11'h400);
        read_match[0 +: MW] = 11'h001;
        in_vld = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            wr_data[0 +: DW] = rnd();
            tick();
        end
        check_eq("t5_saturated", wide_t'(fwd_cnt), wide_t'(16'hFFFF));
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check_eq("t5_clr_wins", wide_t'(fwd_cnt), wide_t'(0));
        tick();
        in_vld = 1'b0;
        check_eq("t5_after_clr", wide_t'(fwd_cnt), wide_t'(1));
        tick();

        // Async reset with skid full.
        out_rdy = 1'b0;
        rand_data();
        set_all(11'h002);
        in_vld = 1'b1;
        tick();
        tick();
        in_vld = 1'b0;
        check_eq("t6_skid_full", wide_t'(in_rdy), wide_t'(0));
        #2;
        rst = 1'b0;
        #1;
        check_eq("t6_out_vld", wide_t'(out_vld), wide_t'(0));
        check_eq("t6_in_rdy", wide_t'(in_rdy), wide_t'(1));
        check_eq("t6_cnt", wide_t'(fwd_cnt), wide_t'(0));
        check_eq("t6_err", wide_t'(err_multi), wide_t'(0));
        check_eq("t6_data", out_data, wide_t'(0));
        tick();
        tick();
        rst = 1'b1;
        out_rdy = 1'b1;
        rand_data();
        set_all(11'h400);
        read_match[5*MW +: MW] = 11'h100;
        in_vld = 1'b1;
        tick();
        in_vld = 1'b0;
        check_eq("t6_post_fwd", wide_t'(out_fwd), wide_t'(9'h020));
        check_eq("t6_post_data5", wide_t'(out_data[5*DW +: DW]), wide_t'(wr_data[8*DW +: DW]));
        tick();
        tick();
        check_eq("sb_empty", wide_t'(sb.size()), wide_t'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
